// File: rtl/lc3b_types.sv
// Shared LC-3b cache types: tag/line widths, the victim-cache controller state
// encoding and the bundle of datapath control strobes it drives.
package lc3b_types;

  typedef logic [11:0]  lc3b_v_tag;
  typedef logic [127:0] lc3b_cache_line;

  typedef enum logic [3:0] {
    IDLE,
    R_LOOKUP,
    R_HIT,
    R_L2ADDR,
    R_L2READ,
    W_LOOKUP,
    W_WBADDR,
    W_WB,
    W_INSTALL,
    DONE
  } victim_ctrl_state;

  typedef struct packed {
    logic inputreg_load;
    logic outputreg_load;
    logic lru_load;
    logic linehitmux_sel;
    logic cacheslot_load;
    logic l2_tagmux_sel;
    logic outputregmux_sel;
    logic dirty_in;
    logic valid_in;
    logic l2_read;
    logic l2_write;
    logic l1_resp;
  } vc_ctrl_t;

endpackage

// File: rtl/victim_cache_control_sat_counter16.sv
// Enable-driven up counter that sticks at all-ones instead of wrapping.
module sat_counter16 #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  output logic [DATA_W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (en && (count != '1))
      count <= count + DATA_W'(1);
  end

endmodule

// File: rtl/victim_cache_control.sv
// Sequencer for the 4-entry victim cache datapath: services L1 fetches and
// L1 evict/installs, drives the L2 handshake and keeps hit/miss statistics.
module victim_cache_control
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        l1_read,
  input  logic        l1_write,
  input  logic        l1_wdirty,
  input  logic        hit,
  input  logic        dirty,
  input  logic        full,
  input  logic        l2_resp,
  output logic        inputreg_load,
  output logic        outputreg_load,
  output logic        lru_load,
  output logic        linehitmux_sel,
  output logic        cacheslot_load,
  output logic        l2_tagmux_sel,
  output logic        outputregmux_sel,
  output logic        dirty_in,
  output logic        valid_in,
  output logic        l2_read,
  output logic        l2_write,
  output logic        l1_resp,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  victim_ctrl_state state, state_nxt;
  vc_ctrl_t         ctrl;
  logic             hit_inc, miss_inc;

  // The datapath picks an empty slot itself, so occupancy never steers the FSM.
  logic unused_full;
  assign unused_full = full;

  always_comb begin
    ctrl      = '0;
    state_nxt = state;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (l1_write) begin
          ctrl.inputreg_load = 1'b1;
          state_nxt          = W_LOOKUP;
        end else if (l1_read) begin
          state_nxt = R_LOOKUP;
        end
      end
      R_LOOKUP: begin
        if (hit) begin
          ctrl.outputreg_load = 1'b1;
          ctrl.lru_load       = 1'b1;
          hit_inc             = 1'b1;
          state_nxt           = R_HIT;
        end else begin
          miss_inc  = 1'b1;
          state_nxt = R_L2ADDR;
        end
      end
      R_HIT: begin
        ctrl.l1_resp = 1'b1;
        state_nxt    = IDLE;
      end
      R_L2ADDR: begin
        ctrl.l2_tagmux_sel = 1'b1;
        state_nxt          = R_L2READ;
      end
      R_L2READ: begin
        ctrl.l2_tagmux_sel    = 1'b1;
        ctrl.outputregmux_sel = 1'b1;
        ctrl.l2_read          = 1'b1;
        if (l2_resp) begin
          ctrl.l1_resp = 1'b1;
          state_nxt    = IDLE;
        end
      end
      W_LOOKUP: begin
        if (hit) begin
          ctrl.cacheslot_load = 1'b1;
          ctrl.lru_load       = 1'b1;
          ctrl.valid_in       = 1'b1;
          ctrl.dirty_in       = l1_wdirty | dirty;
          state_nxt           = DONE;
        end else if (dirty) begin
          ctrl.outputreg_load = 1'b1;
          state_nxt           = W_WBADDR;
        end else begin
          state_nxt = W_INSTALL;
        end
      end
      W_WBADDR: state_nxt = W_WB;
      W_WB: begin
        ctrl.l2_write = 1'b1;
        if (l2_resp)
          state_nxt = W_INSTALL;
      end
      W_INSTALL: begin
        ctrl.cacheslot_load = 1'b1;
        ctrl.lru_load       = 1'b1;
        ctrl.linehitmux_sel = 1'b1;
        ctrl.valid_in       = 1'b1;
        ctrl.dirty_in       = l1_wdirty;
        state_nxt           = DONE;
      end
      DONE: begin
        ctrl.l1_resp = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Mealy strobes must not leak out while reset is held.
    if (!reset_n)
      ctrl = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  assign inputreg_load    = ctrl.inputreg_load;
  assign outputreg_load   = ctrl.outputreg_load;
  assign lru_load         = ctrl.lru_load;
  assign linehitmux_sel   = ctrl.linehitmux_sel;
  assign cacheslot_load   = ctrl.cacheslot_load;
  assign l2_tagmux_sel    = ctrl.l2_tagmux_sel;
  assign outputregmux_sel = ctrl.outputregmux_sel;
  assign dirty_in         = ctrl.dirty_in;
  assign valid_in         = ctrl.valid_in;
  assign l2_read          = ctrl.l2_read;
  assign l2_write         = ctrl.l2_write;
  assign l1_resp          = ctrl.l1_resp;

  sat_counter16 #(.DATA_W(16)) u_hit_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (hit_inc),
    .count   (hit_count)
  );

  sat_counter16 #(.DATA_W(16)) u_miss_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (miss_inc),
    .count   (miss_count)
  );

endmodule

// File: tb/tb_victim_cache_control.sv
// Bench for victim_cache_control: a queue-based victim cache model supplies the
// lookup status and predicts per-request timing, strobes and statistics.
module tb_victim_cache_control;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        l1_read, l1_write, l1_wdirty, hit, dirty, full, l2_resp;
  logic        inputreg_load, outputreg_load, lru_load, linehitmux_sel;
  logic        cacheslot_load, l2_tagmux_sel, outputregmux_sel;
  logic        dirty_in, valid_in, l2_read, l2_write, l1_resp;
  logic [15:0] hit_count, miss_count;
  logic        sat_en;
  logic [3:0]  sat_count;

  always #5 clk = ~clk;

  victim_cache_control dut (
    .clk(clk), .reset_n(reset_n), .l1_read(l1_read), .l1_write(l1_write),
    .l1_wdirty(l1_wdirty), .hit(hit), .dirty(dirty), .full(full), .l2_resp(l2_resp),
    .inputreg_load(inputreg_load), .outputreg_load(outputreg_load), .lru_load(lru_load),
    .linehitmux_sel(linehitmux_sel), .cacheslot_load(cacheslot_load),
    .l2_tagmux_sel(l2_tagmux_sel), .outputregmux_sel(outputregmux_sel),
    .dirty_in(dirty_in), .valid_in(valid_in), .l2_read(l2_read), .l2_write(l2_write),
    .l1_resp(l1_resp), .hit_count(hit_count), .miss_count(miss_count)
  );

  // Narrow instance so saturation is reachable in a short run.
  sat_counter16 #(.DATA_W(4)) u_sat (
    .clk(clk), .reset_n(reset_n), .en(sat_en), .count(sat_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    lc3b_v_tag tag;
    logic      dirty;
  } entry_t;

  entry_t lru_q[$];   // front = least recently used
  int     exp_hits, exp_miss;

  function automatic int find_tag(input lc3b_v_tag t);
    foreach (lru_q[i])
      if (lru_q[i].tag == t) return i;
    return -1;
  endfunction

  // Runs one request starting at posedge+1 with the FSM idle; returns at posedge+1.
  task automatic run_txn(input bit is_wr, input lc3b_v_tag t, input logic wd,
                         input int dly, input bit keep_read);
    int     idx;
    bit     e_hit, e_full;
    logic   e_dirty;
    int     ir_c, or_c, slot_c, slot_n, l2_c, l2_kind, resp_c, resp_n;
    logic   slot_mux, slot_d, slot_v, l2_tm, tm2, omux;
    int     x_resp, x_or, x_slot, x_l2c, x_l2k;
    logic   x_mux, x_d;
    entry_t e;

    idx     = find_tag(t);
    e_hit   = (idx >= 0);
    e_full  = (lru_q.size() == 4);
    e_dirty = e_hit ? lru_q[idx].dirty : (e_full ? lru_q[0].dirty : 1'b0);
    hit = e_hit; dirty = e_dirty; full = e_full; l1_wdirty = wd;
    if (is_wr) l1_write = 1'b1; else l1_read = 1'b1;
    if (keep_read) l1_read = 1'b1;

    ir_c = -1; or_c = -1; slot_c = -1; slot_n = 0; l2_c = -1; l2_kind = 0;
    resp_c = -1; resp_n = 0; slot_mux = 0; slot_d = 0; slot_v = 0;
    l2_tm = 0; tm2 = 0; omux = 0;

    for (int c = 0; c < 60; c++) begin
      l2_resp = (l2_c >= 0) && (c == l2_c + dly);
      @(negedge clk);
      if (inputreg_load && ir_c < 0) ir_c = c;
      if (outputreg_load && or_c < 0) or_c = c;
      if (cacheslot_load) begin
        slot_n++;
        if (slot_c < 0) begin
          slot_c = c; slot_mux = linehitmux_sel; slot_d = dirty_in; slot_v = valid_in;
        end
      end
      if ((l2_read || l2_write) && l2_c < 0) begin
        l2_c = c; l2_kind = l2_write ? 2 : 1; l2_tm = l2_tagmux_sel;
      end
      if (c == 2) tm2 = l2_tagmux_sel;
      if (l1_resp) begin
        resp_n++;
        if (resp_c < 0) begin resp_c = c; omux = outputregmux_sel; end
      end
      @(posedge clk); #1;
      l2_resp = 1'b0;
      if (resp_c >= 0 && c == resp_c) begin
        l1_write = 1'b0;
        if (!keep_read) l1_read = 1'b0;
      end
      if (resp_c >= 0 && c == (keep_read ? resp_c : resp_c + 2)) break;
    end
    if (resp_c < 0) begin l1_read = 1'b0; l1_write = 1'b0; end

    x_or = -1; x_slot = -1; x_l2c = -1; x_l2k = 0; x_mux = 0; x_d = 0;
    if (!is_wr) begin
      if (e_hit) begin x_resp = 2; x_or = 1; end
      else begin x_l2c = 3; x_l2k = 1; x_resp = 3 + dly; end
    end else if (e_hit) begin
      x_resp = 2; x_slot = 1; x_mux = 1'b0; x_d = wd | e_dirty;
    end else if (!e_dirty) begin
      x_resp = 3; x_slot = 2; x_mux = 1'b1; x_d = wd;
    end else begin
      x_or = 1; x_l2c = 3; x_l2k = 2; x_slot = 3 + dly + 1; x_resp = 3 + dly + 2; x_mux = 1'b1; x_d = wd;
    end

    chk("resp_cycle", resp_c, x_resp);
    chk("resp_pulses", resp_n, 1);
    chk("inputreg_cycle", ir_c, is_wr ? 0 : -1);
    chk("outputreg_cycle", or_c, x_or);
    chk("l2_start_cycle", l2_c, x_l2c);
    chk("l2_kind", l2_kind, x_l2k);
    chk("slot_cycle", slot_c, x_slot);
    chk("resp_outmux", omux, (!is_wr && !e_hit) ? 1 : 0);
    if (x_l2k != 0) begin
      chk("l2_tagmux", l2_tm, x_l2k == 1 ? 1 : 0);
      chk("addr_tagmux", tm2, x_l2k == 1 ? 1 : 0);
    end
    if (x_slot >= 0) begin
      chk("slot_loads", slot_n, 1);
      chk("slot_mux", slot_mux, x_mux);
      chk("slot_dirty", slot_d, x_d);
      chk("slot_valid", slot_v, 1);
    end else begin
      chk("slot_loads", slot_n, 0);
    end

    if (!is_wr) begin
      if (e_hit) begin
        e = lru_q[idx]; lru_q.delete(idx); lru_q.push_back(e);
        if (exp_hits < 65535) exp_hits++;
      end else if (exp_miss < 65535) exp_miss++;
    end else if (e_hit) begin
      e = lru_q[idx]; e.dirty = e.dirty | wd; lru_q.delete(idx); lru_q.push_back(e);
    end else begin
      if (e_full) void'(lru_q.pop_front());
      e.tag = t; e.dirty = wd; lru_q.push_back(e);
    end
    chk("hit_count", hit_count, exp_hits);
    chk("miss_count", miss_count, exp_miss);
  endtask

  initial begin
    int   seen;
    logic [11:0] outs;
    reset_n = 1'b0; l1_read = 0; l1_write = 0; l1_wdirty = 0;
    hit = 0; dirty = 0; full = 0; l2_resp = 0; sat_en = 0;
    exp_hits = 0; exp_miss = 0;
    repeat (3) @(posedge clk);
    #1;
    l1_write = 1'b1;
    @(negedge clk);
    outs = {inputreg_load, outputreg_load, lru_load, linehitmux_sel, cacheslot_load,
            l2_tagmux_sel, outputregmux_sel, dirty_in, valid_in, l2_read, l2_write, l1_resp};
    chk("reset_outputs", outs, 0);
    chk("reset_hits", hit_count, 0);
    chk("reset_misses", miss_count, 0);
    chk("reset_state", 32'(dut.state), 32'(IDLE));
    l1_write = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_txn(1, 12'h123, 1'b0, 1, 0);
    run_txn(0, 12'h123, 1'b0, 1, 0);
    run_txn(0, 12'h7FF, 1'b0, 5, 0);
    for (int i = 0; i < 5; i++) run_txn(1, 12'h200 + 12'(i), 1'b1, 3, 0);
    run_txn(1, 12'h300, 1'b1, 2, 1);
    run_txn(0, 12'h300, 1'b0, 2, 0);

    for (int i = 0; i < 40; i++)
      run_txn(1'($urandom_range(0, 1)), 12'h200 + 12'($urandom_range(0, 6)),
              1'($urandom_range(0, 1)), int'($urandom_range(1, 6)), 0);

    // Abort a dirty write-back in flight.
    hit = 0; dirty = 1; full = 1; l1_wdirty = 0; l1_write = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      if (l2_write) seen = 1;
    end
    chk("wb_reached", seen, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_l2_write", l2_write, 0);
    chk("abort_inputreg", inputreg_load, 0);
    chk("abort_state", 32'(dut.state), 32'(IDLE));
    chk("abort_hits", hit_count, 0);
    chk("abort_misses", miss_count, 0);
    l1_write = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    lru_q.delete(); exp_hits = 0; exp_miss = 0;
    @(posedge clk); #1;
    run_txn(0, 12'h055, 1'b0, 2, 0);

    sat_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("sat_mid", sat_count, 10);
    repeat (10) @(posedge clk);
    #1;
    chk("sat_hold", sat_count, 15);
    sat_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/victim_cache_control.md
# victim_cache_control

Sequencing FSM for the 4-entry fully associative victim cache datapath, between the L1 data cache (miss/evict side) and L2. Serves two L1 request types, fetch on L1 miss and install of an L1-evicted line. Drives every datapath load/select, the L2 read/write handshake and the L1 response pulse. Also keeps saturating hit/miss statistics.

## Interface
- No parameters; widths come from `lc3b_types`.
- `clk` in 1: system clock, all state updates on rising edge.
- `reset_n` in 1: reset is asynchronous and active-low.
- `l1_read` in 1: L1 fetch request; held high until `l1_resp`. Datapath `tag` = request tag.
- `l1_write` in 1: L1 evict/install request; held high until `l1_resp`. Datapath `tag` and `l1_tag` = victim tag.
- `l1_wdirty` in 1: dirty bit of the evicted L1 line; valid while `l1_write`.
- `hit` in 1: datapath lookup status.
- `dirty` in 1: datapath lookup status.
- `full` in 1: datapath lookup status.
- `l2_resp` in 1: L2 completion, one-cycle pulse.
- `inputreg_load` out 1: datapath control.
- `outputreg_load` out 1: datapath control.
- `lru_load` out 1: datapath control.
- `linehitmux_sel` out 1: datapath control.
- `cacheslot_load` out 1: datapath control.
- `l2_tagmux_sel` out 1: datapath control.
- `outputregmux_sel` out 1: datapath control.
- `dirty_in` out 1: datapath slot write data.
- `valid_in` out 1: datapath slot write data.
- `l2_read` out 1: L2 request, held until `l2_resp`.
- `l2_write` out 1: L2 request, held until `l2_resp`.
- `l1_resp` out 1: one-cycle completion pulse to L1.
- `hit_count` out 16: saturating count of lookups that hit.
- `miss_count` out 16: saturating count of lookups that missed.

## Operation
- States: IDLE, R_LOOKUP, R_HIT, R_L2ADDR, R_L2READ, W_LOOKUP, W_WBADDR, W_WB, W_INSTALL, DONE.
- IDLE.
  - `l1_write` has priority over `l1_read` when both are high, so a just-evicted line that is re-requested hits.
  - On `l1_write`: assert `inputreg_load` (Mealy), go to W_LOOKUP.
  - Else on `l1_read`: go to R_LOOKUP.
- R_LOOKUP.
  - On `hit`: assert `outputreg_load`, `lru_load` with `linehitmux_sel`=0; increment `hit_count`; go to R_HIT.
  - On miss: increment `miss_count`; go to R_L2ADDR.
- R_HIT: assert `l1_resp` (`outputregmux_sel`=0, so `l1_rdata`/`l1_dirty` come from the output register); go to IDLE.
- R_L2ADDR: assert `l2_tagmux_sel`=1 for one cycle so the address register captures the request tag.
- R_L2READ.
  - Hold `l2_tagmux_sel`=1, `outputregmux_sel`=1, `l2_read`=1.
  - On `l2_resp`, assert `l1_resp` in the same cycle (L2 data passes through with dirty=0); go to IDLE.
  - The victim cache is not filled on this path.
- W_LOOKUP.
  - On `hit`: overwrite the hit slot. Assert `cacheslot_load`, `lru_load`, with `linehitmux_sel`=0, `valid_in`=1, `dirty_in`=`l1_wdirty`|`dirty`. Go to DONE.
  - On miss and `dirty` (the LRU victim): assert `outputreg_load`; go to W_WBADDR.
  - On miss and not `dirty`: go to W_INSTALL.
  - Statistics are not counted on write lookups.
- W_WBADDR: `l2_tagmux_sel`=0 for one cycle, so the address register captures the victim tag.
- W_WB: hold `l2_write`=1 and `l2_tagmux_sel`=0 until `l2_resp`; then go to W_INSTALL.
- W_INSTALL: assert `cacheslot_load`, `lru_load`, with `linehitmux_sel`=1, `valid_in`=1, `dirty_in`=`l1_wdirty`; go to DONE.
- DONE: assert `l1_resp`; go to IDLE.
- Defaults: every control output is 0 unless listed above for the current state.
- Counters:
  - 16-bit, saturate at 0xFFFF (no wrap).
  - Cleared only by reset.
  - Never both increment in one cycle.

## Timing
- Reset: state IDLE; all outputs 0; counters 0.
  - Assertion mid-operation aborts immediately.
  - In-flight `l2_read`/`l2_write` drops the same cycle; L2 must tolerate the abandoned request.
- Request first seen high in IDLE at cycle 0.
  - Read hit: `l1_resp` at cycle 2.
  - Read miss: `l2_read` high from cycle 3; `l1_resp` coincides with `l2_resp`.
  - Write hit: `l1_resp` at cycle 2.
  - Clean write miss: `l1_resp` at cycle 3.
  - Dirty write miss: `l2_write` from cycle 3; `l1_resp` 2 cycles after `l2_resp`.
- `l1_resp` is never asserted twice for one request. A request still high in IDLE after `l1_resp` is a new request.
- `l2_resp` outside R_L2READ/W_WB is ignored.

## Structure
- State enum `victim_ctrl_state` goes in `lc3b_types` so the top level and bench can probe it. Reuse `lc3b_cache_line` and `lc3b_v_tag`.
- One sub-module is natural: `sat_counter16` (enable, async active-low reset), instantiated twice for the statistics.

## Test plan
- Reset, then `l1_write` tag 0x123 dirty=0 into an empty cache → clean miss, `cacheslot_load`+`linehitmux_sel`=1 at cycle 2, `l1_resp` at cycle 3, no `l2_write`.
- `l1_read` tag 0x123 → hit, `outputreg_load` at cycle 1, `l1_resp` at cycle 2, `hit_count`=1, no `l2_read`.
- `l1_read` tag 0x7FF (absent) → `l2_read` from cycle 3; L2 answers after 5 cycles; `l1_resp` with `l2_resp`, `l1_dirty`=0, `miss_count`=1.
- Fill 4 dirty lines, then `l1_write` a fifth tag → `outputreg_load`, `l2_write` with `l2_tagmux_sel`=0, then install; `l1_resp` 2 cycles after `l2_resp`.
- `l1_read` and `l1_write` high together → write serviced first, then read hits the installed tag.
- Drop `reset_n` during W_WB → `l2_write` falls immediately, state IDLE, counters 0. Force 0xFFFF hits → `hit_count` holds 0xFFFF.
